// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, byte/word/state types, column packing and rcon helpers.
// Byte k of a state sits at [8k+7:8k]; column c is [32c+31:32c].
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  localparam aes_byte_t RCON_INIT = 8'h01;
  localparam aes_byte_t RCON_LAST = 8'h36;

  function automatic aes_word_t get_col(input aes_state_t s, input int unsigned c);
    return s[32*c +: 32];
  endfunction

  // Byte0 moves to the byte3 position.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic aes_byte_t xtime(input aes_byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t inv_xtime(input aes_byte_t r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, table driven; entry for input 0 sits in the top byte.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SboxTable[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted handshake, no key store.
// AES_KEY_DEC_ORDER_EN adds a dec input that streams round keys NR..0 after a silent precalc.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef AES_KEY_DEC_ORDER_EN
  input  logic             dec,
`endif
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_index,
  output logic             busy,
  output logic             done
);

  if (NR != AES_NR) begin : gen_bad_nr
    $error("aes_key_expand: only NR = 10 is supported");
  end
  if (KEY_W != AES_KEY_W) begin : gen_bad_key_w
    $error("aes_key_expand: only KEY_W = 128 is supported");
  end

  localparam logic [3:0] LastIdx    = 4'(NR);
  localparam logic [3:0] PreLastIdx = 4'(NR - 1);

  typedef enum logic [1:0] {
    StIdle,
    StEmit
`ifdef AES_KEY_DEC_ORDER_EN
    , StPrecalc
`endif
  } state_e;

  state_e     state_q, state_d;
  aes_state_t rk_data_q, rk_data_d;
  logic [3:0] rk_index_q, rk_index_d;
  aes_byte_t  rcon_q, rcon_d;
  logic       rk_valid_q, rk_valid_d;
  logic       done_q, done_d;

  aes_word_t  k0, k1, k2, k3;
  aes_word_t  sub_src, sub_word, t_word;
  aes_state_t fwd_key;
  logic       xfer, last_key;

  assign k0 = get_col(rk_data_q, 0);
  assign k1 = get_col(rk_data_q, 1);
  assign k2 = get_col(rk_data_q, 2);
  assign k3 = get_col(rk_data_q, 3);

`ifdef AES_KEY_DEC_ORDER_EN
  logic       dec_q, dec_d;
  aes_word_t  p1, p2, p3;
  aes_state_t inv_key;

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;
  // The inverse step runs SubWord on the recovered column 3, not on the current one.
  assign sub_src  = (dec_q && (state_q == StEmit)) ? p3 : k3;
  assign inv_key  = {p3, p2, p1, k0 ^ t_word};
  assign last_key = dec_q ? (rk_index_q == 4'd0) : (rk_index_q == LastIdx);
`else
  assign sub_src  = k3;
  assign last_key = (rk_index_q == LastIdx);
`endif

  for (genvar i = 0; i < 4; i++) begin : gen_sbox
    aes_sbox u_sbox (
      .data_i (rot_word(sub_src)[8*i +: 8]),
      .data_o (sub_word[8*i +: 8])
    );
  end

  assign t_word = sub_word ^ {24'h0, rcon_q};

  always_comb begin
    aes_word_t n0, n1, n2, n3;
    n0 = k0 ^ t_word;
    n1 = k1 ^ n0;
    n2 = k2 ^ n1;
    n3 = k3 ^ n2;
    fwd_key = {n3, n2, n1, n0};
  end

  assign xfer = rk_valid_q & rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef AES_KEY_DEC_ORDER_EN
          state_d = dec ? StPrecalc : StEmit;
`else
          state_d = StEmit;
`endif
        end
      end
      StEmit: begin
        if (xfer && last_key) state_d = StIdle;
      end
`ifdef AES_KEY_DEC_ORDER_EN
      StPrecalc: begin
        if (rk_index_q == PreLastIdx) state_d = StEmit;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
`ifdef AES_KEY_DEC_ORDER_EN
    dec_d      = dec_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rk_data_d  = key_in;
          rk_index_d = '0;
          rcon_d     = RCON_INIT;
          rk_valid_d = 1'b1;
`ifdef AES_KEY_DEC_ORDER_EN
          dec_d = dec;
          if (dec) rk_valid_d = 1'b0;
`endif
        end
      end
      StEmit: begin
        if (xfer) begin
          if (last_key) begin
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end
`ifdef AES_KEY_DEC_ORDER_EN
          else if (dec_q) begin
            rk_data_d  = inv_key;
            rk_index_d = rk_index_q - 4'd1;
            rcon_d     = inv_xtime(rcon_q);
          end
`endif
          else begin
            rk_data_d  = fwd_key;
            rk_index_d = rk_index_q + 4'd1;
            rcon_d     = xtime(rcon_q);
          end
        end
      end
`ifdef AES_KEY_DEC_ORDER_EN
      StPrecalc: begin
        rk_data_d  = fwd_key;
        rk_index_d = rk_index_q + 4'd1;
        rcon_d     = xtime(rcon_q);
        // Last forward step lands on key NR; emit it next with the final round constant.
        if (rk_index_q == PreLastIdx) begin
          rcon_d     = RCON_LAST;
          rk_valid_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rcon_q     <= RCON_INIT;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef AES_KEY_DEC_ORDER_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
`ifdef AES_KEY_DEC_ORDER_EN
      dec_q      <= dec_d;
`endif
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    rk_valid = rk_valid_q;
    rk_data  = rk_data_q;
    rk_index = rk_index_q;
    done     = done_q;
  end

endmodule
